// File: rtl/bin2bcd_if.sv
// Start/done handshake bundle between a binary source and the BCD converter.
// The master drives the operand; the slave reports progress and the held result.
interface bin2bcd_if #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [BIN_W-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  ovf;

  modport master (output start, bin_in, input  busy, done, bcd_out, ovf);
  modport slave  (input  start, bin_in, output busy, done, bcd_out, ovf);
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one operand bit per clock).
// The result is held between conversions so the downstream 7-seg display never flickers.
module bin2bcd_seq #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic      clk,
  input  logic      rst,
  bin2bcd_if.slave  bus
);
  localparam int SW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state;
  logic [SW-1:0]     scr;
  logic [SW-1:0]     scr_adj;
  logic [SW-1:0]     scr_nxt;
  logic [BIN_W-1:0]  opnd;
  logic [CW-1:0]     cnt;
  logic              ovf_s;
  logic              carry;

  // Per-digit correction: any digit >= 5 will become >= 10 after doubling, so pre-add 3.
  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    assign scr_adj[4*i +: 4] = (scr[4*i +: 4] >= 4'd5) ? scr[4*i +: 4] + 4'd3
                                                       : scr[4*i +: 4];
  end

  assign scr_nxt = {scr_adj[SW-2:0], opnd[BIN_W-1]};
  assign carry   = scr_adj[SW-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      scr         <= '0;
      opnd        <= '0;
      cnt         <= '0;
      ovf_s       <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.bcd_out <= '0;
      bus.ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            opnd     <= bus.bin_in;
            scr      <= '0;
            ovf_s    <= 1'b0;
            cnt      <= CW'(BIN_W);
            bus.busy <= 1'b1;
            state    <= SHIFT;
          end else begin
            state    <= IDLE;
          end
        end
        SHIFT: begin
          scr   <= scr_nxt;
          opnd  <= {opnd[BIN_W-2:0], 1'b0};
          ovf_s <= ovf_s | carry;
          cnt   <= cnt - CW'(1);
          // Last iteration: publish directly from the combinational next value.
          if (cnt == CW'(1)) begin
            bus.bcd_out <= scr_nxt;
            bus.ovf     <= ovf_s | carry;
            bus.done    <= 1'b1;
            bus.busy    <= 1'b0;
            state       <= DONE;
          end
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: scoreboard of expected results, one task per scenario.
// A second instance with DIGITS=2 exercises overflow.
module tb_bin2bcd_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bin2bcd_if #(.BIN_W(8), .DIGITS(3)) b1 ();
  bin2bcd_if #(.BIN_W(8), .DIGITS(2)) b2 ();

  bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) dut  (.clk(clk), .rst(rst), .bus(b1.slave));
  bin2bcd_seq #(.BIN_W(8), .DIGITS(2)) dut2 (.clk(clk), .rst(rst), .bus(b2.slave));

  typedef struct { logic [11:0] bcd; logic ovf; } exp_t;
  exp_t sb[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: decimal digits of v, truncated to 'digits', plus overflow flag.
  function automatic exp_t ref_bcd(input int v, input int digits);
    exp_t e;
    int   t;
    int   lim;
    e.bcd = '0;
    t     = v;
    lim   = 1;
    for (int d = 0; d < digits; d++) begin
      e.bcd[4*d +: 4] = 4'(t % 10);
      t   = t / 10;
      lim = lim * 10;
    end
    e.ovf = (v >= lim);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive start for one edge on dut1 and record the expectation.
  task automatic start_conv(input int v);
    b1.start  = 1'b1;
    b1.bin_in = 8'(v);
    sb.push_back(ref_bcd(v, 3));
    tick();
    b1.start  = 1'b0;
  endtask

  // Bounded wait for done on the selected DUT; counts busy cycles on the way.
  task automatic wait_done(input bit sel, output int busy_cnt, output bit seen, output bit overlap);
    busy_cnt = 0;
    seen     = 1'b0;
    overlap  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if ((sel ? b2.done : b1.done) === 1'b1) begin
        seen = 1'b1;
        if ((sel ? b2.busy : b1.busy) === 1'b1) overlap = 1'b1;
        break;
      end
      if ((sel ? b2.busy : b1.busy) === 1'b1) busy_cnt++;
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    total++; if (b1.busy !== 1'b0)       begin bad++; $display("FAIL reset_busy got=%b want=0", b1.busy); end
    total++; if (b1.done !== 1'b0)       begin bad++; $display("FAIL reset_done got=%b want=0", b1.done); end
    total++; if (b1.bcd_out !== 12'h000) begin bad++; $display("FAIL reset_bcd got=%h want=000", b1.bcd_out); end
    total++; if (b1.ovf !== 1'b0)        begin bad++; $display("FAIL reset_ovf got=%b want=0", b1.ovf); end
  endtask

  task automatic test_single();
    int bc; bit seen; bit ov; exp_t e;
    start_conv(9);
    wait_done(1'b0, bc, seen, ov);
    e = sb.pop_front();
    total++; if (!seen)   begin bad++; $display("FAIL single_timeout no done"); end
    total++; if (bc != 8) begin bad++; $display("FAIL single_busy_cycles got=%0d want=8", bc); end
    total++; if (ov)      begin bad++; $display("FAIL single_busy_done_overlap got=1 want=0"); end
    total++; if (b1.bcd_out !== e.bcd) begin bad++; $display("FAIL single_bcd got=%h want=%h", b1.bcd_out, e.bcd); end
    total++; if (b1.bcd_out[3:0] !== 4'b1001) begin bad++; $display("FAIL single_digit0 got=%b want=1001", b1.bcd_out[3:0]); end
    tick();
    total++; if (b1.done !== 1'b0) begin bad++; $display("FAIL single_done_width got=%b want=0", b1.done); end
    repeat (3) tick();
    total++; if (b1.bcd_out !== 12'h009) begin bad++; $display("FAIL single_hold got=%h want=009", b1.bcd_out); end
  endtask

  task automatic test_values();
    int vals[4] = '{0, 99, 100, 255};
    int bc; bit seen; bit ov; exp_t e;
    foreach (vals[i]) begin
      start_conv(vals[i]);
      wait_done(1'b0, bc, seen, ov);
      e = sb.pop_front();
      total++;
      if (!seen || b1.bcd_out !== e.bcd || b1.ovf !== e.ovf) begin
        bad++;
        $display("FAIL value_%0d got=%h/%b want=%h/%b seen=%b", vals[i], b1.bcd_out, b1.ovf, e.bcd, e.ovf, seen);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int bc; bit seen; bit ov; exp_t e; int t1; int t2;
    start_conv(37);
    wait_done(1'b0, bc, seen, ov);
    t1 = cyc;
    e = sb.pop_front();
    total++; if (!seen || b1.bcd_out !== e.bcd) begin bad++; $display("FAIL b2b_first got=%h want=%h", b1.bcd_out, e.bcd); end
    start_conv(200);
    total++; if (b1.busy !== 1'b1) begin bad++; $display("FAIL b2b_no_gap busy=%b want=1", b1.busy); end
    wait_done(1'b0, bc, seen, ov);
    t2 = cyc;
    e = sb.pop_front();
    total++; if (!seen || b1.bcd_out !== e.bcd) begin bad++; $display("FAIL b2b_second got=%h want=%h", b1.bcd_out, e.bcd); end
    total++; if (t2 - t1 != 9) begin bad++; $display("FAIL b2b_spacing got=%0d want=9", t2 - t1); end
    tick();
  endtask

  task automatic test_interference();
    bit seen = 1'b0; exp_t e; int extra = 0;
    start_conv(123);
    for (int i = 0; i < 40; i++) begin
      if (b1.done === 1'b1) begin seen = 1'b1; break; end
      b1.start  = 1'($urandom);
      b1.bin_in = 8'($urandom);
      tick();
    end
    b1.start = 1'b0;
    e = sb.pop_front();
    total++; if (!seen || b1.bcd_out !== e.bcd || b1.ovf !== e.ovf) begin bad++; $display("FAIL interf_result got=%h want=%h seen=%b", b1.bcd_out, e.bcd, seen); end
    for (int i = 0; i < 12; i++) begin
      tick();
      if (b1.busy === 1'b1 || b1.done === 1'b1) extra++;
    end
    total++; if (extra != 0) begin bad++; $display("FAIL interf_extra_conv got=%0d cycles active want=0", extra); end
  endtask

  task automatic test_reset_abort();
    int dn = 0;
    start_conv(255);
    void'(sb.pop_front());
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (b1.done === 1'b1) dn++;
      tick();
    end
    total++; if (dn != 0)               begin bad++; $display("FAIL abort_done got=%0d pulses want=0", dn); end
    total++; if (b1.bcd_out !== 12'h000) begin bad++; $display("FAIL abort_bcd got=%h want=000", b1.bcd_out); end
    total++; if (b1.busy !== 1'b0)      begin bad++; $display("FAIL abort_busy got=%b want=0", b1.busy); end
  endtask

  task automatic test_overflow();
    int bc; bit seen; bit ov; exp_t e;
    e = ref_bcd(255, 2);
    b2.start  = 1'b1;
    b2.bin_in = 8'd255;
    tick();
    b2.start  = 1'b0;
    wait_done(1'b1, bc, seen, ov);
    total++; if (!seen || b2.bcd_out !== e.bcd[7:0]) begin bad++; $display("FAIL ovf_bcd got=%h want=%h seen=%b", b2.bcd_out, e.bcd[7:0], seen); end
    total++; if (b2.ovf !== e.ovf) begin bad++; $display("FAIL ovf_flag got=%b want=%b", b2.ovf, e.ovf); end
    tick();
    b2.start  = 1'b1;
    b2.bin_in = 8'd42;
    tick();
    b2.start  = 1'b0;
    wait_done(1'b1, bc, seen, ov);
    total++; if (!seen || b2.bcd_out !== 8'h42 || b2.ovf !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%h/%b want=42/0", b2.bcd_out, b2.ovf); end
  endtask

  initial begin
    b1.start = 1'b0; b1.bin_in = '0;
    b2.start = 1'b0; b2.bin_in = '0;
    test_reset();
    test_single();
    test_values();
    test_back_to_back();
    test_interference();
    test_reset_abort();
    test_overflow();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
